pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush/redirect controller for the five-stage pipeline: it decides every cycle whether the F and D stage registers hold, which stage registers (D, E, M, W) load a bubble, and where the next PC comes from. It owns the multiply/divide busy counter and a stall-cycle performance counter. It sits beside the stage registers and drives their enable and clear inputs.

## Interface
- MULT_CYC, 5, busy cycles after a mult/multu leaves E
- DIV_CYC, 10, busy cycles after a div/divu leaves E
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- D_Rs, D_Rt  in  5 each  source registers of the D instruction
- D_TuseRs, D_TuseRt  in  2 each  cycles until the operand is needed; 3 = unused
- E_RegAddr, M_RegAddr  in  5 each  destination register in E / M
- E_RegWrite, M_RegWrite  in  1 each  destination valid
- E_Tnew, M_Tnew  in  2 each  cycles until the result is available
- D_IsMD  in  1  D instruction uses HI/LO (mult/div/mf*/mt*)
- E_MDStart  in  1  E holds mult/multu/div/divu
- E_MDIsDiv  in  1  qualifies E_MDStart: 1 = divide
- D_Eret  in  1  D holds eret
- E_MtEpc, M_MtEpc  in  1 each  mtc0 to EPC in E / M
- M_Req  in  1  exception/interrupt accepted at M
- F_En, D_En  out  1 each  PC / D register load enable
- D_Clr, E_Clr, M_Clr, W_Clr  out  1 each  load bubble into that register
- PC_Sel  out  2  0 = sequential/branch, 1 = handler 0x4180, 2 = EPC
- MD_Busy  out  1  multiply/divide unit busy
- Stall_Cnt  out  32  cycles stalled since reset

## Operation
- Data hazard: stall_rs = D_TuseRs≠3 ∧ D_Rs≠0 ∧ ((E_RegWrite ∧ E_RegAddr==D_Rs ∧ E_Tnew>D_TuseRs) ∨ (M_RegWrite ∧ M_RegAddr==D_Rs ∧ M_Tnew>D_TuseRs)); stall_rt likewise.
- MD hazard: stall_md = D_IsMD ∧ (MD_Busy ∨ E_MDStart).
- EPC hazard: stall_epc = D_Eret ∧ (E_MtEpc ∨ M_MtEpc).
- stall = stall_rs ∨ stall_rt ∨ stall_md ∨ stall_epc.
- Priority M_Req > stall > D_Eret:
  - M_Req: F_En=D_En=1, D_Clr=E_Clr=M_Clr=W_Clr=1, PC_Sel=1.
  - stall: F_En=D_En=0, E_Clr=1, other clears 0, PC_Sel=0.
  - D_Eret (no stall): F_En=D_En=1, D_Clr=1, PC_Sel=2.
  - otherwise: enables 1, clears 0, PC_Sel=0.
- MD counter (4 bits): on E_MDStart ∧ ¬M_Req load DIV_CYC or MULT_CYC per E_MDIsDiv; else decrement if nonzero. MD_Busy = count≠0. M_Req does not abort a count already running. A start while busy reloads (cannot occur legally; defined anyway).
- Stall_Cnt increments on every cycle where stall ∧ ¬M_Req; saturates at 0xFFFFFFFF.

## Timing
- All control outputs are combinational from inputs and registered state, valid in the same cycle; stage registers act on them at the next edge.
- Mult in E at cycle t: MD_Busy high cycles t+1..t+MULT_CYC; an mfhi in D stalls cycles t..t+MULT_CYC and proceeds at t+MULT_CYC+1.
- Reset low (any time, mid-count): count=0, Stall_Cnt=0 immediately; with all inputs 0, outputs F_En=D_En=1, clears 0, PC_Sel=0, MD_Busy=0.
- Simultaneous M_Req and E_MDStart: no start, counter keeps decrementing.
- Simultaneous stall and M_Req: flush wins, no stall counted.

## Structure
- Shared package: PC_Sel encodings (PC_NEXT, PC_EXC, PC_EPC), TUSE_NONE=3, EXC_ENTRY=0x4180.
- One sub-module natural: md_busy_ctr (counter, load/decrement, MD_Busy); hazard and priority logic stay in pipe_ctrl.

## Test plan
- lw $1 in E (E_Tnew=2), D add uses $1 (Tuse=1) -> F_En=D_En=0, E_Clr=1 one cycle; next cycle M_Tnew=1 -> no stall; Stall_Cnt=1.
- E_MDStart, E_MDIsDiv=1 at t, D mflo -> stall t..t+10, MD_Busy high t+1..t+10, F_En=1 at t+11.
- M_Req together with data stall and E_MDStart -> all four clears 1, PC_Sel=1, F_En=1, MD_Busy stays 0, Stall_Cnt unchanged.
- D_Eret with M_MtEpc=1 -> stall one cycle; next cycle PC_Sel=2, D_Clr=1.
- Reset pulsed low at t+3 of a 5-cycle mult -> MD_Busy=0 immediately, Stall_Cnt=0, outputs at reset values.
- D_Rs=0 with E writing $0, Tnew=2 -> no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall/flush/redirect
// controller.
//   pc_sel_e   - next-PC source select encodings driven on PC_Sel
//   TUSE_NONE  - Tuse value meaning "operand not read"
//   EXC_ENTRY  - exception handler entry address selected by PC_EXC
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_NEXT = 2'd0,   // sequential / branch target
    PC_EXC  = 2'd1,   // exception handler entry
    PC_EPC  = 2'd2    // return from exception
  } pc_sel_e;

  localparam logic [1:0]  TUSE_NONE = 2'd3;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/pipe_ctrl_md_busy_ctr.sv
// md_busy_ctr: multiply/divide busy counter.
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low reset (clears the count)
//   start  - a mult/div leaves E this cycle (already qualified by the caller)
//   is_div - selects the divide latency for a start
//   busy   - count is nonzero
// A start loads the latency (reloading if already busy); otherwise the count
// decrements to zero and stops.
module md_busy_ctr #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= is_div ? DIV_LD : MULT_LD;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush/redirect controller for the five-stage
// pipeline.
//   clk, reset            - clock (rising edge), async active-low reset
//   D_Rs/D_Rt, D_Tuse*    - D-stage source registers and their use times
//   E_/M_RegAddr/RegWrite/Tnew - pending writers in E and M
//   D_IsMD, E_MDStart, E_MDIsDiv - HI/LO user in D, mult/div leaving E
//   D_Eret, E_MtEpc, M_MtEpc - eret in D, EPC writes in flight
//   M_Req                 - exception/interrupt accepted at M
//   F_En, D_En            - PC / D register load enables
//   D_Clr..W_Clr          - load a bubble into that stage register
//   PC_Sel                - next PC source (pc_sel_e)
//   MD_Busy               - multiply/divide unit busy
//   Stall_Cnt             - saturating count of stalled cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_Rs,
  input  logic [4:0]  D_Rt,
  input  logic [1:0]  D_TuseRs,
  input  logic [1:0]  D_TuseRt,
  input  logic [4:0]  E_RegAddr,
  input  logic [4:0]  M_RegAddr,
  input  logic        E_RegWrite,
  input  logic        M_RegWrite,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_IsMD,
  input  logic        E_MDStart,
  input  logic        E_MDIsDiv,
  input  logic        D_Eret,
  input  logic        E_MtEpc,
  input  logic        M_MtEpc,
  input  logic        M_Req,
  output logic        F_En,
  output logic        D_En,
  output logic        D_Clr,
  output logic        E_Clr,
  output logic        M_Clr,
  output logic        W_Clr,
  output logic [1:0]  PC_Sel,
  output logic        MD_Busy,
  output logic [31:0] Stall_Cnt
);

  logic    stall_rs, stall_rt, stall_md, stall_epc, stall;
  pc_sel_e pc_sel;

  always_comb begin
    stall_rs = (D_TuseRs != TUSE_NONE) && (D_Rs != '0) &&
               ((E_RegWrite && (E_RegAddr == D_Rs) && (E_Tnew > D_TuseRs)) ||
                (M_RegWrite && (M_RegAddr == D_Rs) && (M_Tnew > D_TuseRs)));
    stall_rt = (D_TuseRt != TUSE_NONE) && (D_Rt != '0) &&
               ((E_RegWrite && (E_RegAddr == D_Rt) && (E_Tnew > D_TuseRt)) ||
                (M_RegWrite && (M_RegAddr == D_Rt) && (M_Tnew > D_TuseRt)));
    // A mult/div still in E has not loaded the counter yet, so it counts too.
    stall_md  = D_IsMD && (MD_Busy || E_MDStart);
    stall_epc = D_Eret && (E_MtEpc || M_MtEpc);
    stall     = stall_rs || stall_rt || stall_md || stall_epc;
  end

  // Priority: exception flush > stall > eret redirect.
  always_comb begin
    F_En   = 1'b1;
    D_En   = 1'b1;
    D_Clr  = 1'b0;
    E_Clr  = 1'b0;
    M_Clr  = 1'b0;
    W_Clr  = 1'b0;
    pc_sel = PC_NEXT;
    if (M_Req) begin
      D_Clr  = 1'b1;
      E_Clr  = 1'b1;
      M_Clr  = 1'b1;
      W_Clr  = 1'b1;
      pc_sel = PC_EXC;
    end else if (stall) begin
      F_En  = 1'b0;
      D_En  = 1'b0;
      E_Clr = 1'b1;
    end else if (D_Eret) begin
      D_Clr  = 1'b1;
      pc_sel = PC_EPC;
    end
  end

  assign PC_Sel = pc_sel;

  md_busy_ctr #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start  (E_MDStart && !M_Req),
    .is_div (E_MDIsDiv),
    .busy   (MD_Busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Cnt <= '0;
    end else if (stall && !M_Req && (Stall_Cnt != '1)) begin
      Stall_Cnt <= Stall_Cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  typedef struct {
    logic [4:0] d_rs, d_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] e_addr, m_addr;
    logic       e_we, m_we;
    logic [1:0] e_tnew, m_tnew;
    logic       d_ismd, e_mdstart, e_mdisdiv, d_eret, e_mtepc, m_mtepc, m_req;
  } in_t;

  typedef struct {
    in_t        in;
    logic [8:0] exp_ctrl;  // {F_En,D_En,D_Clr,E_Clr,M_Clr,W_Clr,PC_Sel,MD_Busy}
  } vec_t;

  localparam logic [8:0] C_RUN   = 9'b110000_00_0;
  localparam logic [8:0] C_STALL = 9'b000100_00_0;
  localparam logic [8:0] C_ERET  = 9'b111000_10_0;
  localparam logic [8:0] C_FLUSH = 9'b111111_01_0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  D_Rs, D_Rt, E_RegAddr, M_RegAddr;
  logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
  logic        E_RegWrite, M_RegWrite, D_IsMD, E_MDStart, E_MDIsDiv;
  logic        D_Eret, E_MtEpc, M_MtEpc, M_Req;
  logic        F_En, D_En, D_Clr, E_Clr, M_Clr, W_Clr, MD_Busy;
  logic [1:0]  PC_Sel;
  logic [31:0] Stall_Cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycle number, last busy cycle, stall count.
  int     cyc = 0;
  int     md_last = -1;
  longint scnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
    .E_RegAddr(E_RegAddr), .M_RegAddr(M_RegAddr),
    .E_RegWrite(E_RegWrite), .M_RegWrite(M_RegWrite),
    .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .D_IsMD(D_IsMD), .E_MDStart(E_MDStart), .E_MDIsDiv(E_MDIsDiv),
    .D_Eret(D_Eret), .E_MtEpc(E_MtEpc), .M_MtEpc(M_MtEpc), .M_Req(M_Req),
    .F_En(F_En), .D_En(D_En), .D_Clr(D_Clr), .E_Clr(E_Clr),
    .M_Clr(M_Clr), .W_Clr(W_Clr), .PC_Sel(PC_Sel),
    .MD_Busy(MD_Busy), .Stall_Cnt(Stall_Cnt)
  );

  function automatic logic [8:0] dut_ctrl();
    return {F_En, D_En, D_Clr, E_Clr, M_Clr, W_Clr, PC_Sel, MD_Busy};
  endfunction

  function automatic in_t idle();
    in_t v;
    v = '{d_rs: 0, d_rt: 0, tuse_rs: 3, tuse_rt: 3, e_addr: 0, m_addr: 0,
          e_we: 0, m_we: 0, e_tnew: 0, m_tnew: 0, d_ismd: 0, e_mdstart: 0,
          e_mdisdiv: 0, d_eret: 0, e_mtepc: 0, m_mtepc: 0, m_req: 0};
    return v;
  endfunction

  function automatic in_t zeros();
    in_t v;
    v = idle();
    v.tuse_rs = 0;
    v.tuse_rt = 0;
    return v;
  endfunction

  task automatic apply(input in_t v);
    D_Rs = v.d_rs;  D_Rt = v.d_rt;  D_TuseRs = v.tuse_rs;  D_TuseRt = v.tuse_rt;
    E_RegAddr = v.e_addr;  M_RegAddr = v.m_addr;
    E_RegWrite = v.e_we;  M_RegWrite = v.m_we;
    E_Tnew = v.e_tnew;  M_Tnew = v.m_tnew;
    D_IsMD = v.d_ismd;  E_MDStart = v.e_mdstart;  E_MDIsDiv = v.e_mdisdiv;
    D_Eret = v.d_eret;  E_MtEpc = v.e_mtepc;  M_MtEpc = v.m_mtepc;  M_Req = v.m_req;
  endtask

  // Operand hazard straight from the forwarding-time rule.
  function automatic bit op_hazard(input in_t v, input logic [4:0] r, input logic [1:0] tuse);
    int t;
    t = tuse;
    if (tuse == 2'd3 || r == 5'd0) return 0;
    if (v.e_we && v.e_addr == r && int'(v.e_tnew) > t) return 1;
    if (v.m_we && v.m_addr == r && int'(v.m_tnew) > t) return 1;
    return 0;
  endfunction

  function automatic bit model_busy();
    return cyc <= md_last;
  endfunction

  function automatic bit model_stall(input in_t v);
    return op_hazard(v, v.d_rs, v.tuse_rs) || op_hazard(v, v.d_rt, v.tuse_rt) ||
           (v.d_ismd && (model_busy() || v.e_mdstart)) ||
           (v.d_eret && (v.e_mtepc || v.m_mtepc));
  endfunction

  function automatic logic [8:0] model_ctrl(input in_t v);
    logic [8:0] c;
    if (v.m_req)               c = C_FLUSH;
    else if (model_stall(v))   c = C_STALL;
    else if (v.d_eret)         c = C_ERET;
    else                       c = C_RUN;
    c[0] = model_busy();
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model (and an optional
  // hand-written expectation), then advance the model across the edge.
  task automatic step(input in_t v, input string name, input bit hand_en,
                      input logic [8:0] hand_ctrl);
    @(negedge clk);
    apply(v);
    #1;
    chk({name, "_ctrl"}, 32'(dut_ctrl()), 32'(model_ctrl(v)));
    chk({name, "_cnt"}, Stall_Cnt, 32'(scnt));
    if (hand_en) chk({name, "_hand"}, 32'(dut_ctrl()), 32'(hand_ctrl));
    @(posedge clk);
    if (!v.m_req && model_stall(v) && scnt < 64'hFFFF_FFFF) scnt++;
    if (v.e_mdstart && !v.m_req) md_last = cyc + (v.e_mdisdiv ? 10 : 5);
    cyc++;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    apply(zeros());
    #1;
    chk({name, "_pre"}, 32'(dut_ctrl()), 32'(model_ctrl(zeros())));
    reset = 1'b0;
    #1;
    md_last = -1;
    scnt = 0;
    chk({name, "_ctrl"}, 32'(dut_ctrl()), 32'(C_RUN));
    chk({name, "_cnt"}, Stall_Cnt, 32'd0);
    @(posedge clk);
    cyc++;
    #1 reset = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    in_t v;
    vec_t e;

    apply(zeros());
    // Initial reset held across two edges.
    @(negedge clk); @(negedge clk);
    #1;
    chk("por_ctrl", 32'(dut_ctrl()), 32'(C_RUN));
    chk("por_cnt", Stall_Cnt, 32'd0);
    reset = 1'b1;

    // ---- Table of single-cycle vectors (counter idle) ----
    e.in = idle(); e.exp_ctrl = C_RUN; vecs.push_back(e);
    v = idle(); v.d_rs = 1; v.tuse_rs = 1; v.e_addr = 1; v.e_we = 1; v.e_tnew = 2;
    e.in = v; e.exp_ctrl = C_STALL; vecs.push_back(e);
    v = idle(); v.d_rs = 1; v.tuse_rs = 1; v.m_addr = 1; v.m_we = 1; v.m_tnew = 1;
    e.in = v; e.exp_ctrl = C_RUN; vecs.push_back(e);
    v = idle(); v.d_rs = 0; v.tuse_rs = 0; v.e_addr = 0; v.e_we = 1; v.e_tnew = 2;
    e.in = v; e.exp_ctrl = C_RUN; vecs.push_back(e);
    v = idle(); v.d_rt = 7; v.tuse_rt = 0; v.m_addr = 7; v.m_we = 1; v.m_tnew = 1;
    e.in = v; e.exp_ctrl = C_STALL; vecs.push_back(e);
    v.tuse_rt = 3;
    e.in = v; e.exp_ctrl = C_RUN; vecs.push_back(e);
    v = idle(); v.d_rs = 4; v.tuse_rs = 0; v.e_addr = 4; v.e_we = 0; v.e_tnew = 3;
    e.in = v; e.exp_ctrl = C_RUN; vecs.push_back(e);
    v = idle(); v.d_rs = 4; v.tuse_rs = 2; v.e_addr = 4; v.e_we = 1; v.e_tnew = 2;
    e.in = v; e.exp_ctrl = C_RUN; vecs.push_back(e);
    v = idle(); v.d_eret = 1; v.e_mtepc = 1;
    e.in = v; e.exp_ctrl = C_STALL; vecs.push_back(e);
    v = idle(); v.d_eret = 1;
    e.in = v; e.exp_ctrl = C_ERET; vecs.push_back(e);
    v = idle(); v.d_rs = 2; v.tuse_rs = 0; v.e_addr = 2; v.e_we = 1; v.e_tnew = 1; v.m_req = 1;
    e.in = v; e.exp_ctrl = C_FLUSH; vecs.push_back(e);
    v = idle(); v.d_ismd = 1;
    e.in = v; e.exp_ctrl = C_RUN; vecs.push_back(e);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].in, $sformatf("vec%0d", i), 1'b1, vecs[i].exp_ctrl);

    // ---- lw-use stall: one stall cycle, then resolved from M ----
    do_reset("rst_a");
    v = idle(); v.d_rs = 1; v.tuse_rs = 1; v.e_addr = 1; v.e_we = 1; v.e_tnew = 2;
    step(v, "lw_e", 1'b1, C_STALL);
    v = idle(); v.d_rs = 1; v.tuse_rs = 1; v.m_addr = 1; v.m_we = 1; v.m_tnew = 1;
    step(v, "lw_m", 1'b1, C_RUN);
    @(negedge clk); #1;
    chk("lw_stall_cnt", Stall_Cnt, 32'd1);

    // ---- div in E with mflo in D: stall t..t+10, proceed at t+11 ----
    for (int k = 0; k <= 11; k++) begin
      v = idle(); v.d_ismd = 1;
      if (k == 0) begin v.e_mdstart = 1; v.e_mdisdiv = 1; end
      step(v, $sformatf("div_k%0d", k), 1'b1,
           (k == 11) ? C_RUN : (k == 0) ? C_STALL : (C_STALL | 9'd1));
    end

    // ---- flush beats stall and a mult start ----
    v = idle(); v.d_ismd = 1; v.d_rs = 3; v.tuse_rs = 0; v.e_addr = 3; v.e_we = 1;
    v.e_tnew = 2; v.e_mdstart = 1; v.m_req = 1;
    step(v, "flush", 1'b1, C_FLUSH);
    step(idle(), "flush_after", 1'b1, C_RUN);

    // ---- eret behind an EPC write ----
    v = idle(); v.d_eret = 1; v.m_mtepc = 1;
    step(v, "eret_wait", 1'b1, C_STALL);
    v = idle(); v.d_eret = 1;
    step(v, "eret_go", 1'b1, C_ERET);

    // ---- reset in the middle of a mult ----
    v = idle(); v.e_mdstart = 1;
    step(v, "mult_k0", 1'b1, C_RUN);
    step(idle(), "mult_k1", 1'b1, C_RUN | 9'd1);
    step(idle(), "mult_k2", 1'b1, C_RUN | 9'd1);
    do_reset("rst_mult");

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      v.d_rs      = 5'($urandom_range(0, 3));
      v.d_rt      = 5'($urandom_range(0, 3));
      v.tuse_rs   = 2'($urandom_range(0, 3));
      v.tuse_rt   = 2'($urandom_range(0, 3));
      v.e_addr    = 5'($urandom_range(0, 3));
      v.m_addr    = 5'($urandom_range(0, 3));
      v.e_we      = 1'($urandom_range(0, 1));
      v.m_we      = 1'($urandom_range(0, 1));
      v.e_tnew    = 2'($urandom_range(0, 3));
      v.m_tnew    = 2'($urandom_range(0, 3));
      v.d_ismd    = ($urandom_range(0, 3) == 0);
      v.e_mdstart = ($urandom_range(0, 9) == 0);
      v.e_mdisdiv = 1'($urandom_range(0, 1));
      v.d_eret    = ($urandom_range(0, 7) == 0);
      v.e_mtepc   = ($urandom_range(0, 5) == 0);
      v.m_mtepc   = ($urandom_range(0, 5) == 0);
      v.m_req     = ($urandom_range(0, 15) == 0);
      step(v, "rnd", 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
